// File: rtl/shake_squeeze_dump_if.sv
// -----------------------------------------------------------------------------
// shake_squeeze_dump_if
// Bundles the length request, rate-block input, squeeze request and output word
// stream of the SHAKE squeeze dump controller.
//   slave  : the dump controller side
//   master : the driving side (absorb/permutation logic plus output consumer)
// Signals:
//   len_valid/len_ready/len_in       byte-length request handshake
//   blk_valid/blk_ready/blk_data     rate block from the permutation core
//   squeeze_req                      one-cycle pulse asking for another permutation
//   data_out/valid_out/ready_in      output word stream
//   last_out/keep_out                final-word tag and byte enables
//   busy                             controller is not idle
// -----------------------------------------------------------------------------
interface shake_squeeze_dump_if #(
    parameter int RATE_W = 1344,
    parameter int OUT_W  = 64,
    parameter int LEN_W  = 32
);
    localparam int BPW = OUT_W / 8;

    logic              len_valid;
    logic              len_ready;
    logic [LEN_W-1:0]  len_in;
    logic              blk_valid;
    logic              blk_ready;
    logic [RATE_W-1:0] blk_data;
    logic              squeeze_req;
    logic [OUT_W-1:0]  data_out;
    logic              valid_out;
    logic              ready_in;
    logic              last_out;
    logic [BPW-1:0]    keep_out;
    logic              busy;

    modport slave (
        input  len_valid, len_in, blk_valid, blk_data, ready_in,
        output len_ready, blk_ready, squeeze_req, data_out, valid_out,
               last_out, keep_out, busy
    );

    modport master (
        output len_valid, len_in, blk_valid, blk_data, ready_in,
        input  len_ready, blk_ready, squeeze_req, data_out, valid_out,
               last_out, keep_out, busy
    );
endinterface

// File: rtl/shake_squeeze_dump.sv
// -----------------------------------------------------------------------------
// shake_squeeze_dump
// Output-dump controller for the SHAKE squeeze phase. Takes a byte-length
// request, serialises rate-wide blocks into OUT_W-bit words, pulses squeeze_req
// for every further block needed, and tags the final word with last_out and a
// byte-enable mask.
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   abort  (only with SHAKE_DUMP_ABORT_EN) abandons the current request
//   bus    shake_squeeze_dump_if.slave, see the interface file
// Optional feature macro: SHAKE_DUMP_ABORT_EN
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module shake_squeeze_dump #(
    parameter int RATE_W = 1344,
    parameter int OUT_W  = 64,
    parameter int LEN_W  = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef SHAKE_DUMP_ABORT_EN
    input  logic abort,
`endif
    shake_squeeze_dump_if.slave bus
);
    localparam int WORDS = RATE_W / OUT_W;
    localparam int BPW   = OUT_W / 8;
    localparam int CNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        DUMP     = 2'd2,
        REQ      = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [RATE_W-1:0]  shreg_r;
    logic [LEN_W-1:0]   remaining_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic               last_s;
    logic               hs_s;
    logic               abort_s;
    logic [LEN_W-1:0]   step_s;
    logic [BPW-1:0]     keep_s;

`ifdef SHAKE_DUMP_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign last_s = (state_r == DUMP) && (remaining_r <= LEN_W'(BPW));
    assign hs_s   = (state_r == DUMP) && bus.ready_in;
    // Bytes consumed by one word; clamping keeps remaining from wrapping.
    assign step_s = (remaining_r <= LEN_W'(BPW)) ? remaining_r : LEN_W'(BPW);

    // Next-state decode; abort outside IDLE overrides everything.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.len_valid && (bus.len_in != '0)) begin
                    next_state_s = WAIT_BLK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_BLK: begin
                if (bus.blk_valid) begin
                    next_state_s = DUMP;
                end else begin
                    next_state_s = WAIT_BLK;
                end
            end
            DUMP: begin
                if (hs_s) begin
                    if (last_s) begin
                        next_state_s = IDLE;
                    end else if (word_cnt_r == CNT_W'(1)) begin
                        next_state_s = REQ;
                    end else begin
                        next_state_s = DUMP;
                    end
                end else begin
                    next_state_s = DUMP;
                end
            end
            REQ:     next_state_s = WAIT_BLK;
            default: next_state_s = IDLE;
        endcase
        if (abort_s && (state_r != IDLE)) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: length load, block capture and per-handshake word shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r     <= '0;
            remaining_r <= '0;
            word_cnt_r  <= '0;
        end else if (abort_s && (state_r != IDLE)) begin
            remaining_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.len_valid) begin
                        remaining_r <= bus.len_in;
                    end
                end
                WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        shreg_r    <= bus.blk_data;
                        word_cnt_r <= CNT_W'(WORDS);
                    end
                end
                DUMP: begin
                    if (bus.ready_in) begin
                        shreg_r     <= shreg_r >> OUT_W;
                        remaining_r <= remaining_r - step_s;
                        word_cnt_r  <= word_cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte enables: full word except the last, which covers only remaining bytes.
    always_comb begin
        keep_s = '0;
        if (state_r == DUMP) begin
            if (last_s) begin
                for (int i = 0; i < BPW; i++) begin
                    keep_s[i] = (remaining_r > LEN_W'(i));
                end
            end else begin
                keep_s = '1;
            end
        end else begin
            keep_s = '0;
        end
    end

    assign bus.len_ready   = (state_r == IDLE);
    assign bus.blk_ready   = (state_r == WAIT_BLK);
    assign bus.valid_out   = (state_r == DUMP);
    assign bus.squeeze_req = (state_r == REQ);
    assign bus.busy        = (state_r != IDLE);
    assign bus.last_out    = last_s;
    assign bus.keep_out    = keep_s;
    // Masked outside DUMP so stale state contents never appear on the port.
    assign bus.data_out    = (state_r == DUMP) ? shreg_r[OUT_W-1:0] : '0;

endmodule

// File: tb/tb_shake_squeeze_dump.sv
// -----------------------------------------------------------------------------
// tb_shake_squeeze_dump
// Self-checking bench for shake_squeeze_dump with default parameters
// (168-byte blocks, 8-byte words). The reference is a plain byte stream: the
// expected output is the concatenation of the supplied blocks truncated to the
// requested length, cut into 8-byte words.
// -----------------------------------------------------------------------------
module tb_shake_squeeze_dump;
    localparam int RATE_W = 1344;
    localparam int OUT_W  = 64;
    localparam int LEN_W  = 32;
    localparam int BLK_B  = RATE_W / 8;
    localparam int BPW    = OUT_W / 8;
    localparam int WORDS  = RATE_W / OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SHAKE_DUMP_ABORT_EN
    logic abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] strm [0:511];

    shake_squeeze_dump_if #(.RATE_W(RATE_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

    shake_squeeze_dump #(.RATE_W(RATE_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SHAKE_DUMP_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_block(input int b);
        for (int i = 0; i < BLK_B; i++) bus.blk_data[8*i +: 8] = strm[BLK_B*b + i];
    endtask

    // One full request: offer length, feed blocks on demand, check every word.
    task automatic run_req(input int len, input bit pattern, input int rdy_pct);
        int nblk, nwords, w, given, avail, nsq, cyc;
        bit exp_sq, exp_valid, done;
        logic [63:0] ew;
        logic [7:0]  ek;
        int rem;
        nblk   = (len + BLK_B - 1) / BLK_B;
        nwords = (len + BPW - 1) / BPW;
        for (int i = 0; i < nblk * BLK_B; i++) strm[i] = pattern ? 8'(i) : 8'($urandom);
        bus.len_valid = 1'b1;
        bus.len_in    = LEN_W'(len);
        chk("len_ready_idle", 64'(bus.len_ready), 64'd1);
        @(posedge clk); #1;
        bus.len_valid = 1'b0;
        chk("blk_ready_after_len", 64'(bus.blk_ready), 64'd1);
        w = 0; given = 0; avail = 1; nsq = 0; cyc = 0;
        exp_sq = 1'b0; exp_valid = 1'b0; done = 1'b0;
        while (!done && cyc < 3000) begin
            chk("squeeze_req", 64'(bus.squeeze_req), 64'(exp_sq));
            chk("busy", 64'(bus.busy), 64'd1);
            if (exp_valid) chk("first_word_valid", 64'(bus.valid_out), 64'd1);
            if (bus.squeeze_req) begin
                avail++;
                nsq++;
            end
            exp_sq = 1'b0;
            exp_valid = 1'b0;
            bus.blk_valid = (given < avail) && (given < nblk);
            if (bus.blk_valid) load_block(given);
            if (bus.blk_ready && bus.blk_valid) begin
                given++;
                exp_valid = 1'b1;
            end
            bus.ready_in = (int'($urandom_range(99)) < rdy_pct);
            if (bus.valid_out) begin
                for (int j = 0; j < BPW; j++) ew[8*j +: 8] = strm[BPW*w + j];
                rem = len - BPW * w;
                for (int j = 0; j < BPW; j++) ek[j] = (j < rem);
                chk("data_out", bus.data_out, ew);
                chk("keep_out", 64'(bus.keep_out), 64'(ek));
                chk("last_out", 64'(bus.last_out), 64'(w == nwords - 1));
                if (bus.ready_in) begin
                    if (w == nwords - 1) done = 1'b1;
                    else if ((w + 1) % WORDS == 0) exp_sq = 1'b1;
                    w++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.blk_valid = 1'b0;
        bus.ready_in  = 1'b0;
        chk("request_complete", 64'(done), 64'd1);
        chk("len_ready_after_last", 64'(bus.len_ready), 64'd1);
        chk("valid_after_last", 64'(bus.valid_out), 64'd0);
        chk("squeeze_count", 64'(nsq), 64'(nblk - 1));
        chk("word_count", 64'(w), 64'(nwords));
    endtask

    // Offer a length and one block, then handshake two words so word 3 is on the port.
    task automatic start_dump();
        for (int i = 0; i < BLK_B; i++) strm[i] = 8'($urandom);
        bus.len_valid = 1'b1;
        bus.len_in    = LEN_W'(200);
        @(posedge clk); #1;
        bus.len_valid = 1'b0;
        bus.blk_valid = 1'b1;
        load_block(0);
        @(posedge clk); #1;
        bus.blk_valid = 1'b0;
        bus.ready_in  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("word3_valid", 64'(bus.valid_out), 64'd1);
        chk("word3_data", 64'(bus.data_out[7:0]), 64'(strm[16]));
    endtask

    initial begin
        bus.len_valid = 1'b0;
        bus.len_in    = '0;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.ready_in  = 1'b0;
        #12;
        chk("rst_len_ready", 64'(bus.len_ready), 64'd1);
        chk("rst_blk_ready", 64'(bus.blk_ready), 64'd0);
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_last_out", 64'(bus.last_out), 64'd0);
        chk("rst_squeeze_req", 64'(bus.squeeze_req), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_keep_out", 64'(bus.keep_out), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_req(32, 1'b1, 100);
        run_req(13, 1'b0, 100);
        run_req(200, 1'b0, 100);
        run_req(200, 1'b0, 50);
        run_req(168, 1'b0, 70);
        run_req(169, 1'b0, 100);
        run_req(1, 1'b0, 100);
        for (int k = 0; k < 3; k++) run_req(int'($urandom_range(400, 1)), 1'b0, 65);

        // Zero-length requests are swallowed with no activity.
        bus.len_valid = 1'b1;
        bus.len_in    = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("zero_blk_ready", 64'(bus.blk_ready), 64'd0);
            chk("zero_valid_out", 64'(bus.valid_out), 64'd0);
            chk("zero_squeeze_req", 64'(bus.squeeze_req), 64'd0);
            chk("zero_len_ready", 64'(bus.len_ready), 64'd1);
        end
        bus.len_valid = 1'b0;

        // Asynchronous reset while word 3 is presented.
        start_dump();
        rst = 1'b1;
        #1;
        chk("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("midrst_len_ready", 64'(bus.len_ready), 64'd1);
        chk("midrst_squeeze_req", 64'(bus.squeeze_req), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        bus.ready_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_req(8, 1'b0, 100);

`ifdef SHAKE_DUMP_ABORT_EN
        // Abort wins over a simultaneous handshake.
        start_dump();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.ready_in = 1'b0;
        chk("abort_valid_out", 64'(bus.valid_out), 64'd0);
        chk("abort_len_ready", 64'(bus.len_ready), 64'd1);
        chk("abort_squeeze_req", 64'(bus.squeeze_req), 64'd0);
        chk("abort_last_out", 64'(bus.last_out), 64'd0);
        run_req(16, 1'b0, 60);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
